// File: rtl/pwm_decoder_pkg.sv
// Shared types and defaults for the PWM decoder: FSM state encoding, counter
// defaults and the glitch-filter length used by pwm_in_sync.
package pwm_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_dec_state_t;

  localparam int PWM_DEC_CW       = 16;
  localparam int PWM_DEC_TIMEOUT  = 1024;
  localparam int PWM_DEC_FILT_LEN = 3;

endpackage

// File: rtl/pwm_in_sync.sv
// Input conditioning for pwm_decoder: 2-flop synchronizer, optional glitch
// filter (PWM_DECODER_GLITCH_FILTER_EN) and rise/fall detection on s.
module pwm_in_sync
  import pwm_decoder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pwm_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic s_prev_q;
  logic s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  // s follows the synchronizer only once its current and two previous samples
  // agree; both edges see the same two extra cycles, so widths stay exact.
  logic [PWM_DEC_FILT_LEN-2:0] hist_q;
  logic                        filt_q;
  logic                        all_hi;
  logic                        all_lo;

  always_comb begin
    all_hi = sync2_q & (&hist_q);
    all_lo = ~sync2_q & ~(|hist_q);
    s      = filt_q;
    if (all_hi) begin
      s = 1'b1;
    end else if (all_lo) begin
      s = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[PWM_DEC_FILT_LEN-3:0], sync2_q};
      filt_q <= s;
    end
  end
`else
  assign s = sync2_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev_q <= 1'b0;
    end else begin
      s_prev_q <= s;
    end
  end

  assign s_o    = s;
  assign rise_o = s & ~s_prev_q;
  assign fall_o = ~s & s_prev_q;

endmodule

// File: rtl/pwm_decoder.sv
// Measures high time and rising-to-rising period of an asynchronous PWM input
// in clk cycles, with a stuck-line timeout. Option: PWM_DECODER_GLITCH_FILTER_EN.
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int CW      = PWM_DEC_CW,
  parameter int TIMEOUT = PWM_DEC_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [CW-1:0] high_cnt,
  output logic [CW-1:0] period_cnt,
  output logic          meas_valid,
  output logic          stuck,
  output logic          stuck_level
);

  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  logic           s;
  logic           rise;
  logic           fall;
  pwm_dec_state_t state_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic [CW-1:0]  hi_q;
  logic [CW-1:0]  high_q;
  logic [CW-1:0]  period_q;
  logic           mv_q;
  logic           stuck_q;
  logic           lvl_q;
  logic           at_to;

  pwm_in_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_i  (pwm_in),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign at_to = (cnt_q == TO_C);

  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = CW'(1);
    end else if (!at_to) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      high_q   <= '0;
      period_q <= '0;
      mv_q     <= 1'b0;
      stuck_q  <= 1'b0;
      lvl_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mv_q  <= 1'b0;
      if (fall) begin
        hi_q <= cnt_q;
      end
      case (state_q)
        // A line that never toggles out of reset is reported stuck as well.
        IDLE: begin
          if (rise) begin
            state_q <= HIGH;
            stuck_q <= 1'b0;
          end else if (at_to && !stuck_q) begin
            stuck_q <= 1'b1;
            lvl_q   <= s;
          end
        end
        HIGH: begin
          if (fall) begin
            state_q <= LOW;
          end else if (at_to) begin
            state_q <= IDLE;
            stuck_q <= 1'b1;
            lvl_q   <= s;
          end
        end
        LOW: begin
          if (rise) begin
            state_q  <= HIGH;
            high_q   <= hi_q;
            period_q <= cnt_q;
            mv_q     <= 1'b1;
          end else if (at_to) begin
            state_q <= IDLE;
            stuck_q <= 1'b1;
            lvl_q   <= s;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign high_cnt    = high_q;
  assign period_cnt  = period_q;
  assign meas_valid  = mv_q;
  assign stuck       = stuck_q;
  assign stuck_level = lvl_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder (default build, glitch filter disabled):
// table-driven waveforms, directed stuck/reset/glitch sequences, random periods.
module tb_pwm_decoder;

  localparam int CW = 16;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          pwm_in;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] period_cnt;
  logic          meas_valid;
  logic          stuck;
  logic          stuck_level;

  pwm_decoder #(.CW(CW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .high_cnt    (high_cnt),
    .period_cnt  (period_cnt),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hi;
    int per;
    int cyc;
  } meas_t;

  typedef struct {
    int hi;
    int lo;
    int nper;
    int exp_hi;
    int exp_per;
  } vec_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    dbl_cnt = 0;
  logic  prev_mv = 1'b0;
  meas_t got_q[$];
  meas_t exp_q[$];

  // Reference model state, indexed by the clk edge that samples each level.
  logic  m_prev;
  bit    m_have_rise;
  bit    m_have_fall;
  int    m_rise;
  int    m_fall;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (meas_valid) got_q.push_back('{int'(high_cnt), int'(period_cnt), cyc});
    if (meas_valid && prev_mv) dbl_cnt <= dbl_cnt + 1;
    prev_mv <= meas_valid;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // A period is reported on its closing rise when a fall was seen since the
  // opening rise and the line never went TIMEOUT samples without an edge.
  task automatic drive(input logic v);
    int n;
    @(negedge clk);
    pwm_in = v;
    n = cyc + 1;
    if (v && !m_prev) begin
      if (m_have_rise && m_have_fall && (n - m_rise) <= TO)
        exp_q.push_back('{m_fall - m_rise, n - m_rise, n + 2});
      m_rise      = n;
      m_have_rise = 1'b1;
      m_have_fall = 1'b0;
    end else if (!v && m_prev && m_have_rise) begin
      m_fall      = n;
      m_have_fall = 1'b1;
    end
    m_prev = v;
  endtask

  task automatic drive_n(input logic v, input int k);
    for (int i = 0; i < k; i++) drive(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    rst         = 1'b0;
    m_prev      = 1'b0;
    m_have_rise = 1'b0;
    m_have_fall = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_meas(input string name, input bit use_c, input int c_hi, input int c_per);
    repeat (4) @(negedge clk);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check({name, "_hi"}, got_q[i].hi, exp_q[i].hi);
      check({name, "_per"}, got_q[i].per, exp_q[i].per);
      check({name, "_cyc"}, got_q[i].cyc, exp_q[i].cyc);
      if (use_c) begin
        check({name, "_hi_const"}, got_q[i].hi, c_hi);
        check({name, "_per_const"}, got_q[i].per, c_per);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{64,  192, 3, 64,   256};
    vecs[1] = '{255, 1,   3, 255,  256};
    vecs[2] = '{1,   255, 3, 1,    256};
    vecs[3] = '{1,   1,   4, 1,    2};
    vecs[4] = '{3,   5,   3, 3,    8};
    vecs[5] = '{1000, 24, 2, 1000, 1024};

    rst    = 1'b1;
    pwm_in = 1'b0;
    do_reset();

    check("rst_high_cnt", high_cnt, 0);
    check("rst_period_cnt", period_cnt, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_stuck", stuck, 0);
    check("rst_stuck_level", stuck_level, 0);

    // Table: nper full periods closed by one more rise give nper reports.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int p = 0; p < vecs[v].nper; p++) begin
        drive_n(1'b1, vecs[v].hi);
        drive_n(1'b0, vecs[v].lo);
      end
      drive_n(1'b1, 1);
      drive_n(1'b0, 2);
      check("vec_nreports", exp_q.size(), vecs[v].nper);
      check_meas("vec", 1'b1, vecs[v].exp_hi, vecs[v].exp_per);
    end

    // Constant low from reset.
    do_reset();
    drive_n(1'b0, 1100);
    check("low_stuck", stuck, 1);
    check("low_stuck_level", stuck_level, 0);
    check_meas("low", 1'b0, 0, 0);

    // One valid period, then line held high.
    do_reset();
    drive_n(1'b1, 64);
    drive_n(1'b0, 192);
    drive_n(1'b1, 1100);
    check("high_stuck", stuck, 1);
    check("high_stuck_level", stuck_level, 1);
    check("high_hold_hi", high_cnt, 64);
    check("high_hold_per", period_cnt, 256);
    check_meas("high", 1'b1, 64, 256);

    // Restart from stuck: clears on first rise, report one period later.
    drive_n(1'b0, 192);
    check("restart_still_stuck", stuck, 1);
    drive_n(1'b1, 4);
    check("restart_stuck_clear", stuck, 0);
    drive_n(1'b1, 60);
    drive_n(1'b0, 192);
    check("restart_none_yet", got_q.size(), 0);
    drive_n(1'b1, 64);
    drive_n(1'b0, 192);
    drive_n(1'b1, 2);
    check_meas("restart", 1'b1, 64, 256);

    // Asynchronous reset in the middle of a low phase.
    do_reset();
    drive_n(1'b1, 64);
    drive_n(1'b0, 192);
    drive_n(1'b1, 64);
    drive_n(1'b0, 192);
    drive_n(1'b1, 64);
    drive_n(1'b0, 50);
    check_meas("pre_rst", 1'b1, 64, 256);
    #2;
    rst = 1'b1;
    #1;
    check("arst_high_cnt", high_cnt, 0);
    check("arst_period_cnt", period_cnt, 0);
    check("arst_meas_valid", meas_valid, 0);
    check("arst_stuck", stuck, 0);
    check("arst_stuck_level", stuck_level, 0);
    @(negedge clk);
    rst         = 1'b0;
    m_prev      = 1'b0;
    m_have_rise = 1'b0;
    m_have_fall = 1'b0;
    drive_n(1'b1, 64);
    drive_n(1'b0, 192);
    check("post_rst_none", got_q.size(), 0);
    drive_n(1'b1, 4);
    check_meas("post_rst", 1'b1, 64, 256);

    // One-cycle glitch 100 cycles after the rise splits the period.
    do_reset();
    drive_n(1'b1, 64);
    drive_n(1'b0, 192);
    drive_n(1'b1, 64);
    drive_n(1'b0, 36);
    drive_n(1'b1, 1);
    drive_n(1'b0, 155);
    drive_n(1'b1, 4);
    drive_n(1'b0, 2);
    repeat (4) @(negedge clk);
    check("glitch_count", got_q.size(), 3);
    if (got_q.size() >= 3) begin
      check("glitch_a_hi", got_q[1].hi, 64);
      check("glitch_a_per", got_q[1].per, 100);
      check("glitch_b_hi", got_q[2].hi, 1);
      check("glitch_b_per", got_q[2].per, 156);
    end
    check_meas("glitch", 1'b0, 0, 0);

    // Random periods, occasionally with a long low phase around the timeout.
    do_reset();
    for (int p = 0; p < 150; p++) begin
      int h;
      int l;
      h = $urandom_range(1, 40);
      if ($urandom_range(0, 19) == 0) l = $urandom_range(1000, 1100);
      else l = $urandom_range(1, 40);
      drive_n(1'b1, h);
      drive_n(1'b0, l);
    end
    drive_n(1'b1, 2);
    drive_n(1'b0, 2);
    check_meas("rand", 1'b0, 0, 0);

    check("no_back_to_back", dbl_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
